// File: rtl/immgen_pipe_if.sv
// immgen_pipe_if -- bus bundle for the pipelined RISC-V immediate generator.
//
// Groups the input handshake (in_valid/in_ready plus inst/immsel/in_tag),
// the output handshake (out_valid/out_ready plus imm/out_tag/err) and the
// synchronous flush request.
//   master : the side that issues instructions and consumes immediates
//   slave  : the immediate generator itself
// Parameters must match those of the immgen_pipe instance it connects to.
interface immgen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic [2:0]       immsel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [TAG_W-1:0] out_tag;
  logic             err;

  modport master (
    output flush, in_valid, inst, immsel, in_tag, out_ready,
    input  in_ready, out_valid, imm, out_tag, err
  );

  modport slave (
    input  flush, in_valid, inst, immsel, in_tag, out_ready,
    output in_ready, out_valid, imm, out_tag, err
  );
endinterface

// File: rtl/immgen_pipe.sv
// immgen_pipe -- pipelined immediate generator for the RISC-V decode stage.
//
// Decodes the immediate of the incoming instruction word according to immsel
// (0=R 1=I 2=S 3=B 4=J 5=U 6=Z 7=reserved), sign-extends it to XLEN and
// stores it, with the sideband tag and an error flag, in a two-entry skid
// buffer (main + skid). The main entry drives the outputs, so the result
// appears one cycle after the input transfer; in_ready is a register.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   bus (slave)    flush, in_valid/in_ready, inst, immsel, in_tag,
//                  out_valid/out_ready, imm, out_tag, err
//
// Parameters: XLEN (32 or 64), TAG_W (sideband tag width).
//
// Optional feature: define IMMGEN_ZIMM_EN to decode immsel=6 as the CSR
// zero-extended immediate inst[19:15]; otherwise immsel=6 reports err.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  immgen_pipe_if.slave bus
);

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  // Every format is first built as a 32-bit value whose bit 31 already
  // carries the sign; the final widening to XLEN then just replicates
  // bit 31. The Z immediate has bit 31 clear, so it zero-extends for free.
  logic [31:0]     raw_imm;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  always_comb begin
    raw_imm = '0;
    dec_err = 1'b0;
    case (bus.immsel)
      3'd0: raw_imm = '0;
      3'd1: raw_imm = {{20{bus.inst[31]}}, bus.inst[31:20]};
      3'd2: raw_imm = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
      3'd3: raw_imm = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                       bus.inst[30:25], bus.inst[11:8], 1'b0};
      3'd4: raw_imm = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                       bus.inst[20], bus.inst[30:21], 1'b0};
      3'd5: raw_imm = {bus.inst[31:12], 12'b0};
`ifdef IMMGEN_ZIMM_EN
      3'd6: raw_imm = {27'b0, bus.inst[19:15]};
`else
      3'd6: dec_err = 1'b1;
`endif
      default: dec_err = 1'b1;
    endcase
    dec_imm = XLEN'($signed(raw_imm));
  end

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^bus.inst[6:0];

  // ---------------------------------------------------------------------
  // Two-entry skid buffer
  // ---------------------------------------------------------------------
  logic             main_valid_reg, main_valid_next;
  logic [XLEN-1:0]  main_imm_reg,   main_imm_next;
  logic [TAG_W-1:0] main_tag_reg,   main_tag_next;
  logic             main_err_reg,   main_err_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [XLEN-1:0]  skid_imm_reg,   skid_imm_next;
  logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;
  logic             skid_err_reg,   skid_err_next;
  logic             in_ready_reg,   in_ready_next;
  logic             accept;
  logic             drain;

  assign accept = bus.in_valid && in_ready_reg;
  assign drain  = main_valid_reg && bus.out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_imm_next   = main_imm_reg;
    main_tag_next   = main_tag_reg;
    main_err_next   = main_err_reg;
    skid_valid_next = skid_valid_reg;
    skid_imm_next   = skid_imm_reg;
    skid_tag_next   = skid_tag_reg;
    skid_err_next   = skid_err_reg;

    if (bus.flush) begin
      // Flush wins over both transfers: nothing is accepted or delivered.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_valid_reg && !drain) begin
      // Main is stuck; an accepted entry parks in skid (skid is known empty
      // here because in_ready was high).
      if (accept) begin
        skid_valid_next = 1'b1;
        skid_imm_next   = dec_imm;
        skid_tag_next   = bus.in_tag;
        skid_err_next   = dec_err;
      end
    end else if (skid_valid_reg) begin
      // Main drains while skid holds the older entry: skid moves up. No
      // accept can coincide since in_ready was low.
      main_valid_next = 1'b1;
      main_imm_next   = skid_imm_reg;
      main_tag_next   = skid_tag_reg;
      main_err_next   = skid_err_reg;
      skid_valid_next = 1'b0;
    end else begin
      // Main empty or draining with skid empty: new entry lands in main
      // directly, which keeps out_valid high with no bubble.
      main_valid_next = accept;
      if (accept) begin
        main_imm_next = dec_imm;
        main_tag_next = bus.in_tag;
        main_err_next = dec_err;
      end
    end

    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_imm_reg   <= '0;
      main_tag_reg   <= '0;
      main_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_imm_reg   <= '0;
      skid_tag_reg   <= '0;
      skid_err_reg   <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_valid_reg <= main_valid_next;
      main_imm_reg   <= main_imm_next;
      main_tag_reg   <= main_tag_next;
      main_err_reg   <= main_err_next;
      skid_valid_reg <= skid_valid_next;
      skid_imm_reg   <= skid_imm_next;
      skid_tag_reg   <= skid_tag_next;
      skid_err_reg   <= skid_err_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = main_valid_reg;
  assign bus.imm       = main_imm_reg;
  assign bus.out_tag   = main_tag_reg;
  assign bus.err       = main_err_reg;

endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe -- scoreboard bench for immgen_pipe.
// Drives one XLEN=32 and one XLEN=64 instance with identical stimulus.
// Expected results are queued when an input transfer is issued; per-instance
// monitors pop and compare on every output transfer and check that the
// output holds steady while stalled.
module tb_immgen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  immgen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
  immgen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

  immgen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  immgen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s", nm);
  endtask

  // Reference model: immediate as a signed integer from the bit fields.
  function automatic longint ref_imm(input logic [31:0] i, input logic [2:0] s,
                                     output logic e);
    longint v;
    v = 0;
    e = 1'b0;
    case (s)
      3'd0: v = 0;
      3'd1: begin
        v = longint'(i[31:20]);
        if (i[31]) v -= 4096;
      end
      3'd2: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (i[31]) v -= 4096;
      end
      3'd3: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v -= 8192;
      end
      3'd4: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
          + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) v -= 2097152;
      end
      3'd5: begin
        v = longint'(i[31:12]) * 4096;
        if (i[31]) v -= 64'sd4294967296;
      end
`ifdef IMMGEN_ZIMM_EN
      3'd6: v = longint'(i[19:15]);
`else
      3'd6: e = 1'b1;
`endif
      default: e = 1'b1;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                       input logic [7:0] t);
    b32.in_valid = v; b32.inst = i; b32.immsel = s; b32.in_tag = t;
    b64.in_valid = v; b64.inst = i; b64.immsel = s; b64.in_tag = t;
  endtask

  task automatic set_ordy(input logic r);
    b32.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic set_flush(input logic f);
    b32.flush = f;
    b64.flush = f;
  endtask

  task automatic push(input logic [31:0] e32, input logic [63:0] e64,
                      input logic [7:0] t, input logic e, input logic ok32,
                      input logic ok64);
    exp_t x;
    x.e32 = e32; x.e64 = e64; x.tag = t; x.err = e;
    if (ok32) q32.push_back(x);
    if (ok64) q64.push_back(x);
  endtask

  // Present one entry and hold it until accepted (bounded). If release_after
  // is non-negative, out_ready is raised after that many waiting cycles.
  task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t,
                      input logic [31:0] e32, input logic [63:0] e64, input logic e,
                      input int release_after);
    int waited;
    waited = 0;
    drive(1'b1, i, s, t);
    while (!b32.in_ready) begin
      if (waited == release_after) set_ordy(1'b1);
      if (waited > 50) begin
        fail_now("send_timeout");
        return;
      end
      tick;
      waited++;
    end
    chk("in_ready64_match", b64.in_ready, b32.in_ready);
    push(e32, e64, t, e, 1'b1, 1'b1);
    tick;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    repeat (n) tick;
  endtask

  // ---------------- monitors ----------------
  logic        stall32 = 1'b0;
  logic [31:0] hold_imm32;
  logic [7:0]  hold_tag32;
  logic        hold_err32;

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && !b32.flush) begin
      if (b32.out_valid) begin
        if (stall32) begin
          chk("hold_imm32", b32.imm, hold_imm32);
          chk("hold_tag32", b32.out_tag, hold_tag32);
          chk("hold_err32", b32.err, hold_err32);
        end
        if (b32.out_ready) begin
          if (q32.size() == 0) fail_now("extra_output32");
          else begin
            e = q32.pop_front();
            $display("out32 tag=%02h imm=%08h err=%0b", b32.out_tag, b32.imm, b32.err);
            chk("imm32", b32.imm, e.e32);
            chk("tag32", b32.out_tag, e.tag);
            chk("err32", b32.err, e.err);
          end
        end
      end
      stall32 = b32.out_valid && !b32.out_ready;
      hold_imm32 = b32.imm; hold_tag32 = b32.out_tag; hold_err32 = b32.err;
    end else begin
      stall32 = 1'b0;
    end
  end

  logic        stall64 = 1'b0;
  logic [63:0] hold_imm64;
  logic [7:0]  hold_tag64;
  logic        hold_err64;

  always @(negedge clk) begin : mon64
    exp_t e;
    if (rst_n && !b64.flush) begin
      if (b64.out_valid) begin
        if (stall64) begin
          chk("hold_imm64", b64.imm, hold_imm64);
          chk("hold_tag64", b64.out_tag, hold_tag64);
          chk("hold_err64", b64.err, hold_err64);
        end
        if (b64.out_ready) begin
          if (q64.size() == 0) fail_now("extra_output64");
          else begin
            e = q64.pop_front();
            $display("out64 tag=%02h imm=%016h err=%0b", b64.out_tag, b64.imm, b64.err);
            chk("imm64", b64.imm, e.e64);
            chk("tag64", b64.out_tag, e.tag);
            chk("err64", b64.err, e.err);
          end
        end
      end
      stall64 = b64.out_valid && !b64.out_ready;
      hold_imm64 = b64.imm; hold_tag64 = b64.out_tag; hold_err64 = b64.err;
    end else begin
      stall64 = 1'b0;
    end
  end

  task automatic chk_idle_state(input string nm);
    chk({nm, "_out_valid32"}, b32.out_valid, 1'b0);
    chk({nm, "_in_ready32"},  b32.in_ready,  1'b1);
    chk({nm, "_out_valid64"}, b64.out_valid, 1'b0);
    chk({nm, "_in_ready64"},  b64.in_ready,  1'b1);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk_idle_state(nm);
    chk({nm, "_imm32"}, b32.imm, 32'h0);
    chk({nm, "_tag32"}, b32.out_tag, 8'h0);
    chk({nm, "_err32"}, b32.err, 1'b0);
    chk({nm, "_imm64"}, b64.imm, 64'h0);
    chk({nm, "_tag64"}, b64.out_tag, 8'h0);
    chk({nm, "_err64"}, b64.err, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        v, r, f, e;
    logic [31:0] ri;
    logic [2:0]  rs;
    logic [7:0]  seq;
    longint      m;
    int          budget;

    set_flush(1'b0);
    set_ordy(1'b1);
    drive(1'b0, 32'h0, 3'd0, 8'h0);

    // Reset state
    #1 rst_n = 1'b0;
    #2 chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // I-type, one-cycle latency
    send(32'hFFF00093, 3'd1, 8'h5A, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, -1);
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    chk("latency_out_valid32", b32.out_valid, 1'b1);
    chk("latency_out_valid64", b64.out_valid, 1'b1);
    idle(2);

    // B/J/U/S back-to-back, no bubbles
    send(32'hFE000EE3, 3'd3, 8'h01, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, -1);
    chk("b2b_valid_1", b32.out_valid, 1'b1);
    send(32'h0010006F, 3'd4, 8'h02, 32'h00000800, 64'h0000000000000800, 1'b0, -1);
    chk("b2b_valid_2", b32.out_valid, 1'b1);
    send(32'h123450B7, 3'd5, 8'h03, 32'h12345000, 64'h0000000012345000, 1'b0, -1);
    chk("b2b_valid_3", b32.out_valid, 1'b1);
    send(32'hFE000C23, 3'd2, 8'h04, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, -1);
    chk("b2b_valid_4", b32.out_valid, 1'b1);
    idle(2);

    // Backpressure: two accepts fill the buffer, third waits
    set_ordy(1'b0);
    send(32'h00100093, 3'd1, 8'h11, 32'h00000001, 64'h1, 1'b0, -1);
    send(32'h80000093, 3'd1, 8'h12, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0, -1);
    chk("bp_in_ready_low32", b32.in_ready, 1'b0);
    chk("bp_in_ready_low64", b64.in_ready, 1'b0);
    send(32'h7FF00093, 3'd1, 8'h13, 32'h000007FF, 64'h7FF, 1'b0, 3);
    idle(4);

    // XLEN=64 sign extension of U and I
    send(32'h800000B7, 3'd5, 8'h21, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, -1);
    send(32'h800000B7, 3'd1, 8'h22, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0, -1);

    // Error / optional Z format / R format
    send(32'hFFFFFFFF, 3'd7, 8'h31, 32'h0, 64'h0, 1'b1, -1);
`ifdef IMMGEN_ZIMM_EN
    send(32'h000F8073, 3'd6, 8'h32, 32'h1F, 64'h1F, 1'b0, -1);
`else
    send(32'h000F8073, 3'd6, 8'h32, 32'h0, 64'h0, 1'b1, -1);
`endif
    send(32'hFFFFFFB3, 3'd0, 8'h33, 32'h0, 64'h0, 1'b0, -1);
    idle(3);

    // Flush with both entries full and a concurrent input
    set_ordy(1'b0);
    send(32'h00500093, 3'd1, 8'h41, 32'h5, 64'h5, 1'b0, -1);
    send(32'h00600093, 3'd1, 8'h42, 32'h6, 64'h6, 1'b0, -1);
    set_flush(1'b1);
    drive(1'b1, 32'h00700093, 3'd1, 8'h43);
    q32.delete(); q64.delete();
    tick;
    set_flush(1'b0);
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    chk_idle_state("flush_full");
    set_ordy(1'b1);
    idle(4);

    // Flush with in_ready high and a concurrent input
    set_ordy(1'b0);
    send(32'h00800093, 3'd1, 8'h51, 32'h8, 64'h8, 1'b0, -1);
    chk("flush_pre_in_ready", b32.in_ready, 1'b1);
    set_flush(1'b1);
    drive(1'b1, 32'h00900093, 3'd1, 8'h52);
    q32.delete(); q64.delete();
    tick;
    set_flush(1'b0);
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    chk_idle_state("flush_one");
    set_ordy(1'b1);
    idle(4);

    // Asynchronous reset mid-stream
    set_ordy(1'b0);
    send(32'hFFF00093, 3'd1, 8'h61, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, -1);
    send(32'hFFE00093, 3'd1, 8'h62, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    q32.delete(); q64.delete();
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    set_ordy(1'b1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // Randomized traffic with occasional flush
    seq = 8'h80;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 39) == 0);
      ri = $urandom;
      rs = 3'($urandom_range(0, 7));
      set_ordy(r);
      set_flush(f);
      drive(v, ri, rs, seq);
      if (f) begin
        q32.delete(); q64.delete();
      end else if (v) begin
        m = ref_imm(ri, rs, e);
        push(m[31:0], m, seq, e, b32.in_ready, b64.in_ready);
        if (b32.in_ready) seq++;
      end
      tick;
    end
    set_flush(1'b0);

    // Drain
    drive(1'b0, 32'h0, 3'd0, 8'h0);
    set_ordy(1'b1);
    budget = 0;
    while ((q32.size() != 0 || q64.size() != 0) && budget < 20) begin
      tick;
      budget++;
    end
    if (q32.size() != 0 || q64.size() != 0) fail_now("drain_timeout");
    tick;
    chk_idle_state("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
Parametrised, pipelined immediate generator for the RISC-V decode stage.
- Accepts a raw instruction word plus a format selector and a sideband tag over a valid/ready handshake.
- Outputs the decoded, sign-extended immediate (XLEN wide) one cycle later over a second valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Sits between fetch/decode and the register-read/ALU operand mux.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64; sign extension fills bits XLEN-1 down to the format's top bit.
TAG_W, 8, width of the opaque sideband tag (PC index / ROB id) carried alongside each instruction.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous; drops all buffered entries.
in_valid  in  1  upstream has a valid instruction.
in_ready  out  1  block can accept; registered.
inst  in  32  raw instruction word.
immsel  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=J, 5=U, 6=Z (optional), 7=reserved.
in_tag  in  TAG_W  sideband, passed through unchanged.
out_valid  out  1  imm/out_tag/err valid.
out_ready  in  1  downstream accepts.
imm  out  XLEN  decoded immediate.
out_tag  out  TAG_W  tag of the entry on imm.
err  out  1  entry had an unsupported immsel.

Behaviour:
Reset (rst_n low, async): both entries invalid; out_valid=0, in_ready=1, imm=0, out_tag=0, err=0.

Decode (combinational on the input side; the result is stored in the buffer). sext() means sign extension from inst[31] to XLEN.
- R: imm=0, err=0.
- I: sext(inst[31:20]).
- S: sext({inst[31:25],inst[11:7]}).
- B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
- J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- U: sext({inst[31:12],12'b0}). Upper bits are sign-extended only when XLEN=64.
- 7, and 6 when the optional feature is absent: imm=0, err=1.

Handshake and buffer:
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Main register drives the outputs. The skid register holds one extra entry.
- in_ready = !skid_valid, registered (no combinational in→out path).
- Accept while main empty or main draining this cycle: the entry goes to main.
- Accept while main is full and not draining: the entry goes to skid.
- Main drains while skid is full: skid moves to main and skid clears.
- Simultaneous accept and drain with skid empty: the new entry replaces main. out_valid stays 1 and there is no bubble.
- Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
- Throughput: 1 per cycle while out_ready=1.
- Ordering: strict FIFO. No entry is dropped or duplicated except on flush.
- While out_valid=1 && out_ready=0, imm/out_tag/err hold stable.

Flush:
- Next cycle both entries are invalid, out_valid=0, in_ready=1.
- An input presented in the flush cycle is discarded, even if in_valid && in_ready.
- flush has priority over all transfers.

Reset mid-operation: immediate return to the reset state; no partial entry survives.

Optional Feature:
Macro IMMGEN_ZIMM_EN.
- Defined: immsel=6 (Z) decodes the CSR zero-extended immediate, imm={XLEN-5 zeros, inst[19:15]}, err=0.
- Undefined: immsel=6 behaves as reserved, imm=0, err=1.

Test Plan:
- I-type, XLEN=32: inst=0xFFF00093, immsel=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, err=0, out_tag equals in_tag.
- B/J/U/S, XLEN=32, back-to-back with out_ready=1: -> four consecutive out_valid cycles, in order, no bubbles.
  - 0xFE000EE3 sel3 -> 0xFFFFFFFC.
  - 0x0010006F sel4 -> 0x00000800.
  - 0x123450B7 sel5 -> 0x12345000.
  - 0xFE000C23 sel2 -> 0xFFFFFFF8.
- Backpressure: hold out_ready=0 and push 3 entries -> in_ready falls after 2 accepts; the third waits. Release out_ready -> all 3 emerge in order with values intact.
- XLEN=64: inst=0x800000B7 sel5 -> imm=0xFFFFFFFF80000000. Same word with sel1 -> 0xFFFFFFFFFFFFF800.
- Error and optional feature: sel7 -> imm=0, err=1.
  - sel6 with inst[19:15]=0x1F and IMMGEN_ZIMM_EN defined -> imm=0x1F, err=0.
  - Same stimulus without the macro -> imm=0, err=1.
- Flush/reset: fill both entries, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and no output of the flushed or concurrent entry. Assert rst_n=0 mid-stream -> outputs zero immediately, without waiting for a clock edge.
